// File: rtl/fe_pkg.sv
// rtl/fe_pkg.sv - shared fetch-side constants, prefix helpers and aligner state type
package fe_pkg;

   localparam logic [7:0] PFX_REP  = 8'hF3;
   localparam logic [7:0] PFX_SIZE = 8'h66;
   localparam logic [7:0] PFX_ES   = 8'h26;
   localparam logic [7:0] PFX_CS   = 8'h2E;
   localparam logic [7:0] PFX_SS   = 8'h36;
   localparam logic [7:0] PFX_DS   = 8'h3E;
   localparam logic [7:0] PFX_FS   = 8'h64;
   localparam logic [7:0] PFX_GS   = 8'h65;

   localparam int SEG_ES = 0;
   localparam int SEG_CS = 1;
   localparam int SEG_SS = 2;
   localparam int SEG_DS = 3;
   localparam int SEG_FS = 4;
   localparam int SEG_GS = 5;

   typedef enum logic [1:0] {
      ST_FILL    = 2'd0,
      ST_PRESENT = 2'd1,
      ST_FAULT   = 2'd2
   } aligner_state_e;

   function automatic logic [5:0] seg_onehot(input logic [7:0] b);
      logic [5:0] s;
      s = '0;
      case (b)
         PFX_ES:  s[SEG_ES] = 1'b1;
         PFX_CS:  s[SEG_CS] = 1'b1;
         PFX_SS:  s[SEG_SS] = 1'b1;
         PFX_DS:  s[SEG_DS] = 1'b1;
         PFX_FS:  s[SEG_FS] = 1'b1;
         PFX_GS:  s[SEG_GS] = 1'b1;
         default: s = '0;
      endcase
      return s;
   endfunction

   function automatic logic is_prefix(input logic [7:0] b);
      return (b == PFX_REP) || (b == PFX_SIZE) || (seg_onehot(b) != 6'd0);
   endfunction

endpackage

// File: rtl/prefix_scan.sv
// rtl/prefix_scan.sv - combinational scan of leading prefix bytes in a window
module prefix_scan
   import fe_pkg::*;
#(
   parameter int MAX_PREF = 3
) (
   input  logic [7:0] b1,
   input  logic [7:0] b2,
   input  logic [7:0] b3,
   input  logic [7:0] b4,
   output logic [2:0] n,
   output logic       isREP,
   output logic       isSIZE,
   output logic       isSEG,
   output logic [5:0] segSEL,
   output logic       pfx_err
);

   logic [7:0] b [4];
   logic       run;

   always_comb begin
      b[0]   = b1;
      b[1]   = b2;
      b[2]   = b3;
      b[3]   = b4;
      n      = 3'd0;
      isREP  = 1'b0;
      isSIZE = 1'b0;
      isSEG  = 1'b0;
      segSEL = 6'd0;
      run    = 1'b1;
      // Later segment prefixes overwrite earlier ones, so the highest byte wins.
      for (int i = 0; i < 4; i++) begin
         if (run && is_prefix(b[i])) begin
            n = n + 3'd1;
            if (b[i] == PFX_REP)  isREP  = 1'b1;
            if (b[i] == PFX_SIZE) isSIZE = 1'b1;
            if (seg_onehot(b[i]) != 6'd0) begin
               isSEG  = 1'b1;
               segSEL = seg_onehot(b[i]);
            end
         end else begin
            run = 1'b0;
         end
      end
      pfx_err = (int'(n) > MAX_PREF);
   end

endmodule

// File: rtl/inst_byte_aligner.sv
// rtl/inst_byte_aligner.sv - circular byte queue presenting an aligned 6-byte instruction window
module inst_byte_aligner
   import fe_pkg::*;
#(
   parameter int DEPTH      = 32,
   parameter int LINE_BYTES = 16,
   parameter int WIN        = 6,
   parameter int MAX_PREF   = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         flush,
   input  logic         fetch_valid,
   input  logic [127:0] fetch_data,
   output logic         fetch_ready,
   output logic         dec_valid,
   input  logic         dec_ready,
   input  logic [3:0]   dec_len,
   output logic [7:0]   B1,
   output logic [7:0]   B2,
   output logic [7:0]   B3,
   output logic [7:0]   B4,
   output logic [7:0]   B5,
   output logic [7:0]   B6,
   output logic         isREP,
   output logic         isSIZE,
   output logic         isSEG,
   output logic [3:0]   prefSize,
   output logic [5:0]   segSEL,
   output logic         fault
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int LW = $clog2(LINE_BYTES);

   logic [7:0]     mem [DEPTH];
   logic [AW-1:0]  head, tail;
   logic [CW-1:0]  count;
   aligner_state_e state, state_next;

   logic           push, hs, len_bad, pop;
   logic [CW-1:0]  count_next;
   logic [AW-1:0]  head_next, tail_next;
   logic           fetch_ready_next;
   logic [7:0]     win [WIN];
   logic [AW-1:0]  win_idx [WIN];
   logic [AW-1:0]  win_off [WIN];

   logic [2:0]     scan_n;
   logic           scan_rep, scan_size, scan_seg, scan_err;
   logic [5:0]     scan_sel;

   always_comb begin
      push       = fetch_valid && fetch_ready;
      hs         = dec_valid && dec_ready;
      len_bad    = hs && ((dec_len == 4'd0) || (CW'(dec_len) > count));
      pop        = hs && !len_bad;
      count_next = count;
      head_next  = head;
      tail_next  = tail;
      if (push) begin
         count_next = count_next + CW'(LINE_BYTES);
         tail_next  = tail + AW'(LINE_BYTES);
      end
      if (pop) begin
         count_next = count_next - CW'(dec_len);
         head_next  = head + AW'(dec_len);
      end
      fetch_ready_next = ((DEPTH - int'(count_next)) >= LINE_BYTES);
   end

   // The window must reflect this cycle's write, so bytes landing in the
   // line being pushed are bypassed straight from fetch_data.
   always_comb begin
      for (int k = 0; k < WIN; k++) begin
         win_idx[k] = head_next + AW'(k);
         win_off[k] = win_idx[k] - tail;
         if (push && (win_off[k] < AW'(LINE_BYTES)))
            win[k] = fetch_data[{win_off[k][LW-1:0], 3'b000} +: 8];
         else
            win[k] = mem[win_idx[k]];
      end
   end

   prefix_scan #(
      .MAX_PREF (MAX_PREF)
   ) u_scan (
      .b1      (win[0]),
      .b2      (win[1]),
      .b3      (win[2]),
      .b4      (win[3]),
      .n       (scan_n),
      .isREP   (scan_rep),
      .isSIZE  (scan_size),
      .isSEG   (scan_seg),
      .segSEL  (scan_sel),
      .pfx_err (scan_err)
   );

   always_comb begin
      state_next = ST_FILL;
      if (state == ST_FAULT || len_bad)
         state_next = ST_FAULT;
      else if (int'(count_next) >= WIN)
         state_next = scan_err ? ST_FAULT : ST_PRESENT;
      else
         state_next = ST_FILL;
   end

   always_ff @(posedge clk) begin
      if (reset && !flush && push) begin
         for (int i = 0; i < LINE_BYTES; i++)
            mem[tail + AW'(i)] <= fetch_data[8*i +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= ST_FILL;
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         dec_valid   <= 1'b0;
         fetch_ready <= 1'b1;
         fault       <= 1'b0;
         B1          <= 8'd0;
         B2          <= 8'd0;
         B3          <= 8'd0;
         B4          <= 8'd0;
         B5          <= 8'd0;
         B6          <= 8'd0;
         isREP       <= 1'b0;
         isSIZE      <= 1'b0;
         isSEG       <= 1'b0;
         prefSize    <= 4'b0001;
         segSEL      <= 6'd0;
      end else if (flush) begin
         state       <= ST_FILL;
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         dec_valid   <= 1'b0;
         fetch_ready <= 1'b1;
         fault       <= 1'b0;
      end else begin
         state       <= state_next;
         head        <= head_next;
         tail        <= tail_next;
         count       <= count_next;
         dec_valid   <= (state_next == ST_PRESENT);
         fetch_ready <= fetch_ready_next;
         fault       <= (state_next == ST_FAULT);
         // Window and flags only move when a new instruction is presented.
         if (state_next == ST_PRESENT) begin
            B1     <= win[0];
            B2     <= win[1];
            B3     <= win[2];
            B4     <= win[3];
            B5     <= win[4];
            B6     <= win[5];
            isREP  <= scan_rep;
            isSIZE <= scan_size;
            isSEG  <= scan_seg;
            segSEL <= scan_sel;
            case (scan_n)
               3'd0:    prefSize <= 4'b0001;
               3'd1:    prefSize <= 4'b0010;
               3'd2:    prefSize <= 4'b0100;
               default: prefSize <= 4'b1000;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_inst_byte_aligner.sv
// tb/tb_inst_byte_aligner.sv - directed bench with a byte-queue reference model
module tb_inst_byte_aligner;

   logic         clk = 1'b0;
   logic         reset, flush, fetch_valid, dec_ready;
   logic [127:0] fetch_data;
   logic [3:0]   dec_len;
   logic         fetch_ready, dec_valid, isREP, isSIZE, isSEG, fault;
   logic [7:0]   B1, B2, B3, B4, B5, B6;
   logic [3:0]   prefSize;
   logic [5:0]   segSEL;

   always #5 clk = ~clk;

   inst_byte_aligner dut (
      .clk(clk), .reset(reset), .flush(flush),
      .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_ready(fetch_ready),
      .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_len(dec_len),
      .B1(B1), .B2(B2), .B3(B3), .B4(B4), .B5(B5), .B6(B6),
      .isREP(isREP), .isSIZE(isSIZE), .isSEG(isSEG),
      .prefSize(prefSize), .segSEL(segSEL), .fault(fault)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: a plain byte queue plus the presented window.
   logic [7:0] q [$];
   logic       m_live = 1'b0;
   logic       m_dv, m_fault, m_fr, m_rep, m_size, m_seg;
   logic [7:0] m_b [6];
   logic [3:0] m_pref;
   logic [5:0] m_sel;

   function automatic logic pfx(input logic [7:0] b);
      return b inside {8'hF3, 8'h66, 8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65};
   endfunction

   function automatic logic [5:0] seg_of(input logic [7:0] b);
      case (b)
         8'h26:   return 6'b000001;
         8'h2E:   return 6'b000010;
         8'h36:   return 6'b000100;
         8'h3E:   return 6'b001000;
         8'h64:   return 6'b010000;
         8'h65:   return 6'b100000;
         default: return 6'b000000;
      endcase
   endfunction

   always @(posedge clk) begin
      logic do_push, do_hs, bad;
      int   np;
      m_live = 1'b1;
      if (!reset) begin
         q.delete();
         m_dv = 0; m_fault = 0; m_fr = 1;
         for (int i = 0; i < 6; i++) m_b[i] = 8'd0;
         m_rep = 0; m_size = 0; m_seg = 0; m_pref = 4'b0001; m_sel = 6'd0;
      end else if (flush) begin
         q.delete();
         m_dv = 0; m_fault = 0; m_fr = 1;
      end else begin
         do_push = fetch_valid && m_fr;
         do_hs   = m_dv && dec_ready;
         bad     = do_hs && (dec_len == 0 || int'(dec_len) > q.size());
         if (do_hs && !bad)
            for (int i = 0; i < int'(dec_len); i++) void'(q.pop_front());
         if (do_push)
            for (int i = 0; i < 16; i++) q.push_back(fetch_data[8*i +: 8]);
         if (bad) m_fault = 1;
         m_dv = 0;
         if (!m_fault && q.size() >= 6) begin
            np = 0;
            while (np < 4 && pfx(q[np])) np++;
            if (np == 4) begin
               m_fault = 1;
            end else begin
               m_dv = 1;
               for (int i = 0; i < 6; i++) m_b[i] = q[i];
               m_rep = 0; m_size = 0; m_seg = 0; m_sel = 6'd0;
               for (int i = 0; i < np; i++) begin
                  if (q[i] == 8'hF3) m_rep = 1;
                  if (q[i] == 8'h66) m_size = 1;
                  if (seg_of(q[i]) != 0) begin m_seg = 1; m_sel = seg_of(q[i]); end
               end
               m_pref = 4'(1 << np);
            end
         end
         m_fr = (32 - q.size()) >= 16;
      end
   end

   always @(negedge clk) begin
      if (m_live) begin
         check("dec_valid", 32'(dec_valid), 32'(m_dv));
         check("fault", 32'(fault), 32'(m_fault));
         check("fetch_ready", 32'(fetch_ready), 32'(m_fr));
         check("window", {B1, B2, B3, B4}, {m_b[0], m_b[1], m_b[2], m_b[3]});
         check("window_hi", {16'd0, B5, B6}, {16'd0, m_b[4], m_b[5]});
         check("flags", {19'd0, isREP, isSIZE, isSEG, prefSize, segSEL},
               {19'd0, m_rep, m_size, m_seg, m_pref, m_sel});
      end
   end

   function automatic logic [127:0] seq_line(input logic [7:0] base);
      logic [127:0] l;
      for (int i = 0; i < 16; i++) l[8*i +: 8] = base + 8'(i);
      return l;
   endfunction

   task automatic step(input logic fv, input logic [127:0] d, input logic dr,
                       input logic [3:0] len, input logic fl);
      fetch_valid = fv;
      fetch_data  = d;
      dec_ready   = dr;
      dec_len     = len;
      flush       = fl;
      @(negedge clk);
   endtask

   task automatic idle();
      step(1'b0, '0, 1'b0, 4'd0, 1'b0);
   endtask

   task automatic do_flush();
      step(1'b0, '0, 1'b0, 4'd0, 1'b1);
   endtask

   logic [127:0] l2, l3a, l3b, lx, ly;

   initial begin
      reset = 1'b0; flush = 1'b0; fetch_valid = 1'b0; fetch_data = '0;
      dec_ready = 1'b0; dec_len = 4'd0;
      repeat (2) @(negedge clk);
      check("lit_reset_dv", 32'(dec_valid), 32'd0);
      check("lit_reset_fr", 32'(fetch_ready), 32'd1);
      check("lit_reset_pref", 32'(prefSize), 32'b0001);
      check("lit_reset_b1", 32'(B1), 32'd0);
      reset = 1'b1;

      // Plain line of NOPs
      step(1'b1, {16{8'h90}}, 1'b0, 4'd0, 1'b0);
      check("lit_nop_dv", 32'(dec_valid), 32'd1);
      check("lit_nop_win", {B1, B2, B3, B6}, 32'h90909090);
      check("lit_nop_pref", 32'(prefSize), 32'b0001);
      check("lit_nop_fr", 32'(fetch_ready), 32'd1);
      do_flush();
      check("lit_flush_dv", 32'(dec_valid), 32'd0);

      // Three prefixes then consume 5
      l2 = seq_line(8'h10);
      l2[39:0] = 40'hC0_01_F3_2E_66;
      step(1'b1, l2, 1'b0, 4'd0, 1'b0);
      check("lit_p3_pref", 32'(prefSize), 32'b1000);
      check("lit_p3_flags", {29'd0, isREP, isSIZE, isSEG}, 32'b111);
      check("lit_p3_seg", 32'(segSEL), 32'b000010);
      check("lit_p3_b4", 32'(B4), 32'h01);
      step(1'b0, '0, 1'b1, 4'd5, 1'b0);
      check("lit_adv_b1", 32'(B1), 32'h15);
      check("lit_adv_pref", 32'(prefSize), 32'b0001);
      do_flush();

      // Last segment wins, then a four-prefix window reaches the head
      l3a = {16{8'h90}};
      l3a[23:0] = 24'h8B_64_26;
      l3b = {16{8'h90}};
      l3b[31:0] = 32'h66666666;
      step(1'b1, l3a, 1'b0, 4'd0, 1'b0);
      check("lit_fs_seg", 32'(segSEL), 32'b010000);
      check("lit_fs_pref", 32'(prefSize), 32'b0100);
      step(1'b1, l3b, 1'b0, 4'd0, 1'b0);
      check("lit_full_fr", 32'(fetch_ready), 32'd0);
      step(1'b0, '0, 1'b1, 4'd15, 1'b0);
      check("lit_pre4_win", {16'd0, B1, B2}, 32'h9066);
      step(1'b0, '0, 1'b1, 4'd1, 1'b0);
      check("lit_p4_fault", 32'(fault), 32'd1);
      check("lit_p4_dv", 32'(dec_valid), 32'd0);
      idle();
      check("lit_fault_sticky", 32'(fault), 32'd1);
      do_flush();
      check("lit_unfault", 32'(fault), 32'd0);

      // Full queue, consume with blocked push
      step(1'b1, seq_line(8'h40), 1'b0, 4'd0, 1'b0);
      step(1'b1, seq_line(8'h50), 1'b0, 4'd0, 1'b0);
      check("lit_32_fr", 32'(fetch_ready), 32'd0);
      step(1'b1, seq_line(8'hC0), 1'b1, 4'd15, 1'b0);
      check("lit_17_win", {16'd0, B1, B2}, 32'h4F50);
      step(1'b0, '0, 1'b1, 4'd15, 1'b0);
      check("lit_2_dv", 32'(dec_valid), 32'd0);
      check("lit_2_fr", 32'(fetch_ready), 32'd1);
      do_flush();

      // Wrap of the head across the end of the queue
      step(1'b1, seq_line(8'h80), 1'b0, 4'd0, 1'b0);
      step(1'b1, seq_line(8'h90), 1'b1, 4'd4, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b1, seq_line(8'hA0), 1'b1, 4'd4, 1'b0);
      step(1'b0, '0, 1'b1, 4'd4, 1'b0);
      step(1'b0, '0, 1'b1, 4'd4, 1'b0);
      check("lit_wrap_lo", {B1, B2, B3, B4}, 32'h9C9D9E9F);
      check("lit_wrap_hi", {16'd0, B5, B6}, 32'hA0A1);
      for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 4'd4, 1'b0);
      check("lit_low_dv", 32'(dec_valid), 32'd0);
      step(1'b1, seq_line(8'hB0), 1'b1, 4'd4, 1'b0);
      check("lit_refill_dv", 32'(dec_valid), 32'd1);
      check("lit_refill_b1", 32'(B1), 32'hAC);

      // Flush beats a simultaneous push and consume
      lx = seq_line(8'h00);
      ly = seq_line(8'hD0);
      step(1'b1, lx, 1'b1, 4'd4, 1'b1);
      check("lit_fl_dv", 32'(dec_valid), 32'd0);
      check("lit_fl_fr", 32'(fetch_ready), 32'd1);
      idle();
      idle();
      check("lit_fl_empty", 32'(dec_valid), 32'd0);
      step(1'b1, ly, 1'b0, 4'd0, 1'b0);
      check("lit_fl_new_b1", 32'(B1), 32'hD0);

      // Illegal lengths
      do_flush();
      step(1'b1, seq_line(8'h80), 1'b0, 4'd0, 1'b0);
      step(1'b0, '0, 1'b1, 4'd0, 1'b0);
      check("lit_len0_fault", 32'(fault), 32'd1);
      do_flush();
      step(1'b1, seq_line(8'h80), 1'b0, 4'd0, 1'b0);
      step(1'b0, '0, 1'b1, 4'd5, 1'b0);
      step(1'b0, '0, 1'b1, 4'd12, 1'b0);
      check("lit_over_fault", 32'(fault), 32'd1);
      check("lit_over_dv", 32'(dec_valid), 32'd0);

      // Reset mid-operation
      do_flush();
      step(1'b1, seq_line(8'h80), 1'b0, 4'd0, 1'b0);
      reset = 1'b0;
      idle();
      check("lit_rst_b1", 32'(B1), 32'd0);
      check("lit_rst_dv", 32'(dec_valid), 32'd0);
      reset = 1'b1;
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
